// File: rtl/fifo_arb_pkg.sv
// Shared types and helpers for the FIFO write-port arbiter.
// The round-robin search is written for up to 8 requesters.
package fifo_arb_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    localparam logic [15:0] STALL_MAX = 16'hFFFF;
    localparam int unsigned MAX_REQ   = 8;

    // Returns {found, index}. The search starts at last+1 and wraps modulo n,
    // so `last` itself is the lowest-priority candidate.
    function automatic logic [3:0] rr_pick(
        input logic [MAX_REQ-1:0] req,
        input logic [2:0]         last,
        input int unsigned        n
    );
        logic        found;
        logic [2:0]  idx;
        int unsigned cand;
        found = 1'b0;
        idx   = '0;
        for (int unsigned k = 1; k <= n; k++) begin
            cand = 32'(last) + k;
            if (cand >= n) cand = cand - n;
            if (!found && req[cand[2:0]]) begin
                found = 1'b1;
                idx   = cand[2:0];
            end
        end
        return {found, idx};
    endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_picker.sv
// Combinational round-robin priority search over NREQ request lines.
module rr_picker
    import fifo_arb_pkg::*;
#(
    parameter  int NREQ = 4,
    localparam int IDW  = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  last,
    output logic            found,
    output logic [IDW-1:0]  idx
);

    logic [MAX_REQ-1:0] req_ext;
    logic [2:0]         last_ext;
    logic [3:0]         pick;

    always_comb begin
        req_ext             = '0;
        req_ext[NREQ-1:0]   = req;
        last_ext            = '0;
        last_ext[IDW-1:0]   = last;
        pick                = rr_pick(req_ext, last_ext, NREQ);
    end

    assign found = pick[3];
    assign idx   = IDW'(pick[2:0]);

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin, burst-limited sharing of the byte FIFO write port among NREQ
// producers, with a saturating stall counter for FIFO sizing.
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter  int NREQ  = 4,
    parameter  int DW    = 8,
    parameter  int BURST = 4,
    localparam int IDW   = $clog2(NREQ)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [NREQ-1:0]  req_valid,
    input  logic [NREQ*DW-1:0] req_data,
    output logic [NREQ-1:0]  req_ready,
    input  logic             fifo_full,
    output logic             fifo_wr,
    output logic [DW-1:0]    fifo_wdata,
    output logic [IDW-1:0]   grant_id,
    output logic             busy,
    output logic [15:0]      stall_cnt
);

    localparam logic [4:0] BURST_LAST = 5'(BURST - 1);

    state_t         state;
    logic [IDW-1:0] last_grant;
    logic [4:0]     burst_cnt;

    logic           holder_valid;
    logic           xfer;
    logic           rel;
    logic           found;
    logic [IDW-1:0] winner;

    assign busy = (state == GRANT);

    rr_picker #(.NREQ(NREQ)) u_picker (
        .req   (req_valid),
        .last  (last_grant),
        .found (found),
        .idx   (winner)
    );

    // Handshake outputs are gated by reset so a word presented in the reset
    // cycle of an active burst is neither accepted nor written.
    always_comb begin
        holder_valid = req_valid[grant_id];
        req_ready    = '0;
        fifo_wdata   = '0;
        xfer         = busy & holder_valid & ~fifo_full & reset;
        if (busy && reset) req_ready[grant_id] = ~fifo_full;
        fifo_wr = xfer;
        if (xfer) fifo_wdata = req_data[grant_id*DW +: DW];
        rel = busy & (~holder_valid | (xfer & (burst_cnt == BURST_LAST)));
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= IDLE;
            grant_id   <= '0;
            last_grant <= IDW'(NREQ - 1);
            burst_cnt  <= '0;
            stall_cnt  <= '0;
        end else begin
            if (busy && holder_valid && fifo_full && stall_cnt != STALL_MAX)
                stall_cnt <= stall_cnt + 16'd1;

            // last_grant equals grant_id while granted, so one picker serves
            // both the idle arbitration and the same-cycle hand-over.
            if ((state == IDLE || rel) && found) begin
                state      <= GRANT;
                grant_id   <= winner;
                last_grant <= winner;
                burst_cnt  <= '0;
            end else if (rel) begin
                state <= IDLE;
            end else if (xfer) begin
                burst_cnt <= burst_cnt + 5'd1;
            end
        end
    end

endmodule
